// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order memory requests and
// buffers returned words with their PCs for the IF/ID register, discarding stale responses after redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [1:0]  outstanding
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int QW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];
    logic [QW-1:0] q_head, q_tail;
    logic [CW-1:0] q_count;
    logic [31:0]   tag_pc  [MAX_OUT];
    logic [TW-1:0] tag_head, tag_tail;
    logic [1:0]    drop_cnt;

    logic       req_fire, q_push, q_pop;
    logic [1:0] outstanding_next;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
    endfunction

    // Words already queued count against the issue budget so every response has a slot.
    always_comb begin
        imem_req_valid = !rst && !redirect_valid
                         && (int'(outstanding) < MAX_OUT)
                         && (int'(outstanding) + int'(q_count) < QDEPTH);
    end

    assign imem_req_addr    = fetch_pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign q_push           = imem_rsp_valid && (drop_cnt == 2'd0) && !redirect_valid;
    assign q_pop            = out_valid && out_ready && !redirect_valid;
    assign outstanding_next = outstanding + {1'b0, req_fire} - {1'b0, imem_rsp_valid};

    assign out_valid = (q_count != '0);
    assign out_pc    = out_valid ? q_pc[q_head]    : 32'h0;
    assign out_instr = out_valid ? q_instr[q_head] : NOP;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            q_head      <= '0;
            q_tail      <= '0;
            q_count     <= '0;
            tag_head    <= '0;
            tag_tail    <= '0;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old stream.
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                q_head   <= '0;
                q_tail   <= '0;
                q_count  <= '0;
                tag_head <= '0;
                tag_tail <= '0;
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    tag_tail <= tag_inc(tag_tail);
                end
                if (imem_rsp_valid && (drop_cnt != 2'd0))
                    drop_cnt <= drop_cnt - 2'd1;
                if (q_push) begin
                    q_tail   <= q_tail + QW'(1);
                    tag_head <= tag_inc(tag_head);
                end
                if (q_pop)
                    q_head <= q_head + QW'(1);
                case ({q_push, q_pop})
                    2'b10:   q_count <= q_count + CW'(1);
                    2'b01:   q_count <= q_count - CW'(1);
                    default: q_count <= q_count;
                endcase
            end
        end
    end

    // NOTE: storage arrays carry no reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (req_fire)
            tag_pc[tag_tail] <= fetch_pc;
        if (q_push) begin
            q_pc[q_tail]    <= tag_pc[tag_head];
            q_instr[q_tail] <= imem_rsp_data;
        end
    end

    q_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(q_push && !q_pop && (int'(q_count) == QDEPTH)));
    rsp_without_req_a: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (outstanding == 2'd0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory model with programmable latency
// feeds the DUT while a scoreboard of expected (pc, instr) pairs checks the output stream.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [1:0]  outstanding;

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(2), .MAX_OUT(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; int due; } mem_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mem_t        mem_q[$];
    exp_t        exp_q[$];
    int          cyc, mo, mem_lat, n_pop;
    int          n_vec, n_err;
    logic [31:0] exp_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic step();
        logic acc;
        logic rsp;
        exp_t e;
        rsp = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].data;
            void'(mem_q.pop_front());
            rsp = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        #1;
        n_vec++;
        if (outstanding !== 2'(mo)) begin
            n_err++;
            $display("FAIL outstanding cyc=%0d: got %0d want %0d", cyc, outstanding, mo);
        end
        acc = imem_req_valid && imem_req_ready;
        if (redirect_valid) begin
            n_vec++;
            if (imem_req_valid !== 1'b0) begin
                n_err++;
                $display("FAIL req_in_redirect cyc=%0d: got %b want 0", cyc, imem_req_valid);
            end
            exp_q.delete();
            exp_addr = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (acc) begin
                n_vec++;
                if (imem_req_addr !== exp_addr) begin
                    n_err++;
                    $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, imem_req_addr, exp_addr);
                end
                mem_q.push_back('{data: mem_word(imem_req_addr), due: cyc + mem_lat});
                exp_q.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
                exp_addr = exp_addr + 32'd4;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out cyc=%0d: got pc %h, want nothing", cyc, out_pc);
                end else begin
                    e = exp_q.pop_front();
                    n_pop++;
                    if (out_pc !== e.pc || out_instr !== e.instr) begin
                        n_err++;
                        $display("FAIL out_pair cyc=%0d: got %h/%h want %h/%h",
                                 cyc, out_pc, out_instr, e.pc, e.instr);
                    end
                end
            end
        end
        mo = mo + (acc ? 1 : 0) - (rsp ? 1 : 0);
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 ||
            out_instr !== NOP || outstanding !== 2'd0) begin
            n_err++;
            $display("FAIL %s: got rv=%b ov=%b pc=%h in=%h os=%0d want 0/0/0/%h/0", tag,
                     imem_req_valid, out_valid, out_pc, out_instr, outstanding, NOP);
        end
    endtask

    task automatic restart_models();
        mem_q.delete();
        exp_q.delete();
        cyc      = 0;
        mo       = 0;
        exp_addr = RESET_PC;
    endtask

    task automatic expect_pops(input string tag, input int start, input int min_pops);
        n_vec++;
        if (n_pop - start < min_pops) begin
            n_err++;
            $display("FAIL %s_progress: got %0d outputs want >= %0d", tag, n_pop - start, min_pops);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset_values");
        restart_models();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int start;
        start   = n_pop;
        mem_lat = 1;
        for (int i = 0; i < 20; i++) begin
            if (i <= 2) begin
                n_vec++;
                if (out_valid !== (i == 2)) begin
                    n_err++;
                    $display("FAIL first_out_timing cyc=%0d: got %b want %b", i, out_valid, i == 2);
                end
            end
            step();
        end
        expect_pops("stream", start, 8);
    endtask

    task automatic test_hold();
        int start;
        mem_lat   = 1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i >= 4) begin
                n_vec++;
                if (exp_q.size() == 0 || imem_req_valid !== 1'b0 || out_valid !== 1'b1 ||
                    out_pc !== exp_q[0].pc || out_instr !== exp_q[0].instr) begin
                    n_err++;
                    $display("FAIL hold cyc=%0d: got rv=%b ov=%b pc=%h want rv=0 ov=1 pc=%h",
                             cyc, imem_req_valid, out_valid, out_pc,
                             (exp_q.size() > 0) ? exp_q[0].pc : 32'hX);
                end
            end
            step();
        end
        out_ready = 1'b1;
        start     = n_pop;
        repeat (10) step();
        expect_pops("hold_release", start, 5);
    endtask

    task automatic test_redirect();
        int start;
        int guard;
        mem_lat = 3;
        guard   = 0;
        while (mo != 2 && guard < 12) begin
            step();
            guard++;
        end
        n_vec++;
        if (mo != 2 || outstanding !== 2'd2) begin
            n_err++;
            $display("FAIL redirect_setup: got outstanding %0d want 2", outstanding);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_flush: got out_valid %b want 0", out_valid);
        end
        start = n_pop;
        repeat (20) step();
        expect_pops("redirect", start, 4);
    endtask

    task automatic test_redirect_collide();
        int   start;
        logic found;
        mem_lat = 1;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid && mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
            else step();
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL collide_setup: got no rsp+output cycle want one within 20");
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL collide_flush: got out_valid %b want 0", out_valid);
        end
        start = n_pop;
        repeat (10) step();
        expect_pops("collide", start, 3);
    endtask

    task automatic test_req_stall();
        int          start;
        logic [31:0] held;
        mem_lat = 2;
        repeat (4) step();
        imem_req_ready = 1'b0;
        held = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (imem_req_addr !== held || imem_req_addr !== exp_addr) begin
                n_err++;
                $display("FAIL stall_addr cyc=%0d: got %h want %h", cyc, imem_req_addr, exp_addr);
            end
            if (i >= 3) begin
                n_vec++;
                if (imem_req_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_valid cyc=%0d: got %b want 1", cyc, imem_req_valid);
                end
            end
            step();
        end
        imem_req_ready = 1'b1;
        start = n_pop;
        repeat (10) step();
        expect_pops("stall_release", start, 4);
    endtask

    task automatic test_wrap_and_reset();
        int start;
        int guard;
        mem_lat        = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF4;
        step();
        redirect_valid = 1'b0;
        start = n_pop;
        repeat (12) step();
        expect_pops("wrap", start, 5);

        guard = 0;
        while (!out_valid && guard < 10) begin
            step();
            guard++;
        end
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_setup: got out_valid %b want 1", out_valid);
        end
        #2;
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        #1;
        check_reset_outputs("midstream_reset");
        @(negedge clk);
        restart_models();
        rst   = 1'b0;
        start = n_pop;
        repeat (10) step();
        expect_pops("post_reset", start, 4);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_pop = 0;
        restart_models();
        mem_lat = 1;
        test_reset();
        test_stream();
        test_hold();
        test_redirect();
        test_redirect_collide();
        test_req_stall();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1);
    end

endmodule
